// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave in front of a single-port synchronous SRAM: writes complete with zero wait,
// reads take one wait state, and illegal size/alignment gets the two-cycle ERROR response.
module ahb_sram_ctrl #(
  parameter int AW = 14
) (
  input  logic          hclk,
  input  logic          hresetn,
  input  logic          hsel,
  input  logic [31:0]   haddr,
  input  logic [1:0]    htrans,
  input  logic [1:0]    hsize,
  input  logic          hwrite,
  input  logic [31:0]   hwdata,
  input  logic          hready,
  output logic          hreadyout,
  output logic [1:0]    hresp,
  output logic [31:0]   hrdata,
  output logic          sram_cs,
  output logic          sram_we,
  output logic [3:0]    sram_be,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD1,
    S_RD2,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW+1:0] addr_q;
  logic [1:0]    size_q;
  logic          write_q;

  logic          accept;
  logic          can_accept;
  logic          take;
  logic          illegal;
  logic [3:0]    be;
  logic          unused_bits;

  assign accept     = hsel && htrans[1] && hready;
  // RD1 and ERR1 hold the bus low, so no address phase can complete in them
  assign can_accept = (state != S_RD1) && (state != S_ERR1);
  assign take       = accept && can_accept;

  assign illegal = (hsize == 2'b11) ||
                   ((hsize == 2'b01) && haddr[0]) ||
                   ((hsize == 2'b10) && (haddr[1:0] != 2'b00));

  always_comb begin
    be = 4'b1111;
    case (size_q)
      2'b00:   be = 4'b0001 << addr_q[1:0];
      2'b01:   be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  always_comb begin
    state_nxt = state;
    hreadyout = 1'b1;
    hresp     = 2'b00;
    sram_cs   = 1'b0;
    case (state)
      S_WR:    sram_cs = 1'b1;
      S_RD1: begin
        sram_cs   = 1'b1;
        hreadyout = 1'b0;
      end
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 2'b01;
      end
      S_ERR2:  hresp = 2'b01;
      default: ;
    endcase

    case (state)
      S_RD1:  state_nxt = S_RD2;
      S_ERR1: state_nxt = S_ERR2;
      default: begin
        if (!take)        state_nxt = S_IDLE;
        else if (illegal) state_nxt = S_ERR1;
        else if (hwrite)  state_nxt = S_WR;
        else              state_nxt = S_RD1;
      end
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      size_q  <= 2'b00;
      write_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        addr_q  <= haddr[AW+1:0];
        size_q  <= hsize;
        write_q <= hwrite;
      end
    end
  end

  assign sram_we    = sram_cs && write_q;
  assign sram_be    = sram_cs ? be : 4'b0000;
  assign sram_addr  = addr_q[AW+1:2];
  assign sram_wdata = hwdata;
  assign hrdata     = (state == S_RD2) ? sram_rdata : 32'h0;

  // Address bits above the SRAM span wrap; htrans[0] (SEQ vs NONSEQ) needs no distinction here
  assign unused_bits = &{1'b0, haddr[31:AW+2], htrans[0]};

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Bench for ahb_sram_ctrl: directed corner cases, then random transfers checked against
// a byte-addressed reference memory; a small SRAM model answers the controller's strobes.
module tb_ahb_sram_ctrl;
  localparam int AW = 8;
  localparam int NW = 1 << AW;

  logic          hclk = 1'b0;
  logic          hresetn = 1'b0;
  logic          hsel = 1'b0;
  logic [31:0]   haddr = 32'h0;
  logic [1:0]    htrans = 2'b00;
  logic [1:0]    hsize = 2'b00;
  logic          hwrite = 1'b0;
  logic [31:0]   hwdata = 32'h0;
  logic          hready;
  logic          force_nrdy = 1'b0;
  logic          hreadyout;
  logic [1:0]    hresp;
  logic [31:0]   hrdata;
  logic          sram_cs;
  logic          sram_we;
  logic [3:0]    sram_be;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;
  logic          mem_init = 1'b0;

  logic [31:0]   sram [NW];
  logic [7:0]    ref_mem [int];
  int            compared = 0;
  int            mismatched = 0;

  assign hready = hreadyout && !force_nrdy;

  ahb_sram_ctrl #(.AW(AW)) dut (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .hsel       (hsel),
    .haddr      (haddr),
    .htrans     (htrans),
    .hsize      (hsize),
    .hwrite     (hwrite),
    .hwdata     (hwdata),
    .hready     (hready),
    .hreadyout  (hreadyout),
    .hresp      (hresp),
    .hrdata     (hrdata),
    .sram_cs    (sram_cs),
    .sram_we    (sram_we),
    .sram_be    (sram_be),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always #5 hclk = ~hclk;

  always @(posedge hclk) begin
    if (mem_init) begin
      for (int i = 0; i < NW; i++) sram[i] <= 32'h0;
    end else if (sram_cs) begin
      if (sram_we) begin
        for (int l = 0; l < 4; l++)
          if (sram_be[l]) sram[sram_addr][8*l +: 8] <= sram_wdata[8*l +: 8];
      end else begin
        sram_rdata <= sram[sram_addr];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: summary not reached within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_legal(input logic [31:0] a, input logic [1:0] s);
    int unsigned n;
    if (s == 2'b11) return 1'b0;
    n = 1 << s;
    return (a % n) == 0;
  endfunction

  function automatic logic [3:0] exp_lanes(input logic [31:0] a, input logic [1:0] s);
    logic [3:0] m;
    m = 4'b0000;
    for (int k = 0; k < (1 << s); k++) m[(a % 4) + k] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return 32'((a >> 2) % NW);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] w;
    int          base;
    w    = 32'h0;
    base = int'(a % (4 * NW)) & ~3;
    for (int k = 0; k < 4; k++)
      if (ref_mem.exists(base + k)) w[8*k +: 8] = ref_mem[base + k];
    return w;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    for (int k = 0; k < (1 << s); k++)
      ref_mem[int'(a % (4 * NW)) + k] = d[8*((a + k) % 4) +: 8];
  endtask

  // Entered at posedge+1 of the first data-phase cycle; leaves at posedge+1 after the last.
  task automatic data_phase(input logic wr, input logic [31:0] a, input logic [1:0] s,
                            input logic [31:0] d);
    if (!is_legal(a, s)) begin
      @(negedge hclk);
      chk("err1_rdy", hreadyout, 1'b0);
      chk("err1_resp", hresp, 2'b01);
      chk("err1_cs", sram_cs, 1'b0);
      @(posedge hclk); #1;
      @(negedge hclk);
      chk("err2_rdy", hreadyout, 1'b1);
      chk("err2_resp", hresp, 2'b01);
      chk("err2_cs", sram_cs, 1'b0);
    end else if (wr) begin
      @(negedge hclk);
      chk("wr_cs", sram_cs, 1'b1);
      chk("wr_we", sram_we, 1'b1);
      chk("wr_be", sram_be, exp_lanes(a, s));
      chk("wr_addr", sram_addr, exp_word(a));
      chk("wr_wdata", sram_wdata, d);
      chk("wr_rdy", hreadyout, 1'b1);
      chk("wr_resp", hresp, 2'b00);
      ref_write(a, s, d);
    end else begin
      @(negedge hclk);
      chk("rd1_cs", sram_cs, 1'b1);
      chk("rd1_we", sram_we, 1'b0);
      chk("rd1_be", sram_be, exp_lanes(a, s));
      chk("rd1_addr", sram_addr, exp_word(a));
      chk("rd1_rdy", hreadyout, 1'b0);
      chk("rd1_resp", hresp, 2'b00);
      chk("rd1_rdata", hrdata, 32'h0);
      @(posedge hclk); #1;
      @(negedge hclk);
      chk("rd2_rdy", hreadyout, 1'b1);
      chk("rd2_resp", hresp, 2'b00);
      chk("rd2_cs", sram_cs, 1'b0);
      chk("rd2_rdata", hrdata, ref_word(a));
    end
    @(posedge hclk); #1;
  endtask

  task automatic xfer(input logic wr, input logic [31:0] a, input logic [1:0] s,
                      input logic [31:0] d);
    hsel = 1'b1; htrans = 2'b10; haddr = a; hsize = s; hwrite = wr;
    @(posedge hclk); #1;
    // scramble the idle address phase so only registered attributes can be used
    hsel = 1'b0; htrans = 2'b00; haddr = $urandom; hsize = 2'($urandom); hwrite = ~wr;
    hwdata = d;
    data_phase(wr, a, s, d);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] a;
    logic [1:0]  s;
    logic        wr;

    mem_init = 1'b1;
    repeat (2) @(posedge hclk);
    #1;
    mem_init = 1'b0;
    @(negedge hclk);
    chk("rst_rdy", hreadyout, 1'b1);
    chk("rst_resp", hresp, 2'b00);
    chk("rst_rdata", hrdata, 32'h0);
    chk("rst_cs", sram_cs, 1'b0);
    chk("rst_we", sram_we, 1'b0);
    chk("rst_be", sram_be, 4'b0000);
    chk("rst_addr", sram_addr, 32'h0);
    @(posedge hclk); #1;
    hresetn = 1'b1;

    // byte write into lane 3, then word read of the same word
    xfer(1'b1, 32'h13, 2'b00, 32'hAA00_0000);
    xfer(1'b0, 32'h10, 2'b10, 32'h0);
    xfer(1'b1, 32'h10, 2'b10, 32'hDEAD_BEEF);

    // back-to-back reads: second address waits through RD1, accepted in RD2
    xfer(1'b1, 32'h0, 2'b10, $urandom);
    xfer(1'b1, 32'h4, 2'b10, $urandom);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h0; hsize = 2'b10; hwrite = 1'b0;
    @(posedge hclk); #1;
    haddr = 32'h4;
    @(negedge hclk);
    chk("p_rd1a_rdy", hreadyout, 1'b0);
    chk("p_rd1a_cs", sram_cs, 1'b1);
    chk("p_rd1a_addr", sram_addr, 32'h0);
    @(posedge hclk); #1;
    @(negedge hclk);
    chk("p_rd2a_rdy", hreadyout, 1'b1);
    chk("p_rd2a_data", hrdata, ref_word(32'h0));
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00;
    @(negedge hclk);
    chk("p_rd1b_rdy", hreadyout, 1'b0);
    chk("p_rd1b_cs", sram_cs, 1'b1);
    chk("p_rd1b_addr", sram_addr, 32'h1);
    @(posedge hclk); #1;
    @(negedge hclk);
    chk("p_rd2b_rdy", hreadyout, 1'b1);
    chk("p_rd2b_data", hrdata, ref_word(32'h4));
    @(posedge hclk); #1;
    @(negedge hclk);
    chk("p_idle_cs", sram_cs, 1'b0);
    chk("p_idle_rdy", hreadyout, 1'b1);
    @(posedge hclk); #1;

    // write immediately followed by a read of the same word
    v = $urandom;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h20; hsize = 2'b10; hwrite = 1'b1;
    @(posedge hclk); #1;
    hwdata = v; hwrite = 1'b0;
    @(negedge hclk);
    chk("h_wr_cs", sram_cs, 1'b1);
    chk("h_wr_we", sram_we, 1'b1);
    chk("h_wr_rdy", hreadyout, 1'b1);
    ref_write(32'h20, 2'b10, v);
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00;
    @(negedge hclk);
    chk("h_rd1_cs", sram_cs, 1'b1);
    chk("h_rd1_we", sram_we, 1'b0);
    @(posedge hclk); #1;
    @(negedge hclk);
    chk("h_rd2_data", hrdata, ref_word(32'h20));
    @(posedge hclk); #1;

    // illegal transfers
    xfer(1'b1, 32'h1, 2'b01, 32'h1234_5678);
    xfer(1'b0, 32'h8, 2'b11, 32'h0);
    xfer(1'b0, 32'h6, 2'b10, 32'h0);

    // reset during RD1 drops the strobe and clears registered attributes
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h4; hsize = 2'b10; hwrite = 1'b0;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hresetn = 1'b0;
    @(negedge hclk);
    chk("r_rd1_cs", sram_cs, 1'b1);
    @(posedge hclk); #1;
    @(negedge hclk);
    chk("r_rst_rdy", hreadyout, 1'b1);
    chk("r_rst_resp", hresp, 2'b00);
    chk("r_rst_cs", sram_cs, 1'b0);
    chk("r_rst_rdata", hrdata, 32'h0);
    chk("r_rst_addr", sram_addr, 32'h0);
    @(posedge hclk); #1;
    hresetn = 1'b1;
    xfer(1'b0, 32'h4, 2'b10, 32'h0);

    // address phase held while another slave stalls the bus
    force_nrdy = 1'b1;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h30; hsize = 2'b10; hwrite = 1'b1;
    repeat (3) begin
      @(posedge hclk); #1;
      @(negedge hclk);
      chk("s_cs", sram_cs, 1'b0);
    end
    force_nrdy = 1'b0; hsel = 1'b0; htrans = 2'b00;
    @(posedge hclk); #1;
    @(negedge hclk);
    chk("s_after_cs", sram_cs, 1'b0);
    chk("s_after_rdy", hreadyout, 1'b1);
    @(posedge hclk); #1;

    // random traffic over a few words with aliased upper address bits
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        hsel = 1'($urandom_range(0, 1));
        htrans = hsel ? {1'b0, 1'($urandom_range(0, 1))} : 2'($urandom);
        haddr = $urandom; hsize = 2'($urandom); hwrite = 1'($urandom);
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'b00;
        @(negedge hclk);
        chk("n_cs", sram_cs, 1'b0);
        chk("n_rdy", hreadyout, 1'b1);
        chk("n_resp", hresp, 2'b00);
        @(posedge hclk); #1;
      end else begin
        s = 2'($urandom_range(0, 3));
        wr = 1'($urandom_range(0, 1));
        a = $urandom;
        a[9:2] = 8'($urandom_range(0, 15));
        if (s != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~((32'h1 << s) - 32'h1);
        xfer(wr, a, s, $urandom);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ahb_sram_ctrl.md
AHB_SRAM_CTRL -- requirements
Module: ahb_sram_ctrl

Interface
REQ-001 SHALL have parameter AW, default 14, meaning SRAM word-address width (4*2^AW bytes mapped).
REQ-002 SHALL have port hclk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 SHALL have port hresetn, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port hsel, input, 1 bit: slave select, address phase.
REQ-005 SHALL have port haddr, input, 32 bits: byte address, address phase.
REQ-006 SHALL have port htrans, input, 2 bits: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-007 SHALL have port hsize, input, 2 bits: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 SHALL have port hwrite, input, 1 bit: 1 = write.
REQ-009 SHALL have port hwdata, input, 32 bits: write data, valid in the data phase.
REQ-010 SHALL have port hready, input, 1 bit: bus-level ready; the previous transfer completes when high.
REQ-011 SHALL have port hreadyout, output, 1 bit: this slave's ready.
REQ-012 SHALL have port hresp, output, 2 bits: 00 OKAY, 01 ERROR.
REQ-013 SHALL have port hrdata, output, 32 bits: read data.
REQ-014 SHALL have port sram_cs, output, 1 bit: SRAM access strobe, one cycle per access.
REQ-015 SHALL have port sram_we, output, 1 bit: 1 = write, qualified by sram_cs.
REQ-016 SHALL have port sram_be, output, 4 bits: byte enables, bit n = byte lane n (little-endian).
REQ-017 SHALL have port sram_addr, output, AW bits: word address haddr[AW+1:2].
REQ-018 SHALL have port sram_wdata, output, 32 bits: equals hwdata combinationally.
REQ-019 SHALL have port sram_rdata, input, 32 bits: read data, valid the cycle after sram_cs with sram_we=0.

Function
REQ-020 SHALL accept a transfer on a rising edge where hsel=1, htrans[1]=1, and hready=1; the controller SHALL register haddr, hsize, and hwrite.
REQ-021 SHALL treat IDLE/BUSY, or hsel=0, with hready=1 as no transfer; the next cycle SHALL return OKAY with zero wait.
REQ-022 SHALL flag a transfer illegal on hsize=11, on hsize=01 with haddr[0]=1, or on hsize=10 with haddr[1:0]!=00.
REQ-023 SHALL derive byte enables from the registered attributes: byte = 0001<<haddr[1:0]; half = haddr[1] ? 1100 : 0011; word = 1111.
REQ-024 SHALL implement states IDLE, WR, RD1, RD2, ERR1, ERR2.
REQ-025 IDLE: hreadyout=1, hresp=00, sram_cs=0; transitions: accepted legal write -> WR; legal read -> RD1; illegal -> ERR1.
REQ-026 WR (zero-wait data phase): sram_cs=1, sram_we=1, sram_be/sram_addr from registered attributes, hreadyout=1, hresp=00; next state SHALL follow REQ-025 using the transfer accepted this cycle.
REQ-027 RD1: sram_cs=1, sram_we=0, hreadyout=0, hresp=00; the next state SHALL be RD2 unconditionally.
REQ-028 RD2: hrdata=sram_rdata, hreadyout=1, hresp=00, sram_cs=0; next state per REQ-025 (pipelined acceptance).
REQ-029 ERR1: hreadyout=0, hresp=01, sram_cs=0; the next state SHALL be ERR2.
REQ-030 ERR2: hreadyout=1, hresp=01; next state per REQ-025.
REQ-031 SHALL make every read one wait state (2-cycle data phase) and every write zero wait.
REQ-032 SHALL add no hazard logic for write-then-read to the same address, because the write reaches SRAM before the read strobe.
REQ-033 SHALL drive hrdata=0 whenever the state is not RD2.
REQ-034 SHALL never produce an SRAM access for an illegal or unselected transfer.
REQ-035 SHALL ignore haddr bits above AW+1, which wrap modulo the SRAM size.
REQ-036 SHALL ignore the address phase while hready=0 (other slave stalling).

Reset
REQ-037 While hresetn=0 at a rising edge, the state SHALL go to IDLE and the registered attributes SHALL clear, including mid-transfer.
REQ-038 Outputs after reset: hreadyout=1, hresp=00, hrdata=0, sram_cs=0, sram_we=0, sram_be=0000, sram_addr=0.
REQ-039 Any SRAM strobe pending at reset SHALL be dropped; the first transfer SHALL be accepted the cycle hresetn rises.

Verification
REQ-040 Word write 0x0000_0010, data 0xDEADBEEF -> data-phase sram_cs=1, sram_we=1, be=1111, addr=4, hreadyout=1, OKAY.
REQ-041 Byte write 0x13, then word read 0x10 with SRAM holding 0xAA000000 -> be=1000; the read shows hreadyout 0 then 1, and hrdata=0xAA000000 on the second cycle.
REQ-042 Back-to-back NONSEQ reads 0x0, 0x4 -> each completes in 2 cycles, second address accepted in the first read's RD2 cycle, 4 cycles total.
REQ-043 Halfword at 0x1 and hsize=11 -> each gives the two-cycle ERROR (hreadyout 0/01, then 1/01) with sram_cs never asserted.
REQ-044 hresetn low during RD1 -> the next cycle shows hreadyout=1, hresp=00, sram_cs=0; a fresh read after release completes normally.
REQ-045 hsel=1 and NONSEQ with hready=0 -> not accepted; no SRAM access occurs.
